// File: rtl/preset_shift_reg.sv
// Multi-mode WIDTH-bit register: hold, parallel load, shift left/right, with shift counter and done flag.
// Optional synchronous preset input Pre is compiled in when PRESET_SHREG_PRESET_EN is defined.
module preset_shift_reg #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       CLR,
`ifdef PRESET_SHREG_PRESET_EN
    input  logic                       Pre,
`endif
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin,
    output logic [WIDTH-1:0]           q,
    output logic                       sout,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic [CW-1:0]    cnt_inc;
    logic             preset_hit;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

`ifdef PRESET_SHREG_PRESET_EN
    assign preset_hit = Pre;
`else
    assign preset_hit = 1'b0;
`endif

    // Serial input enters at the LSB for left shifts and at the MSB for right shifts.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = sin;
            end else begin : g_shl
                assign shl_vec[gi] = data_q[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_vec[gi] = sin;
            end else begin : g_shr
                assign shr_vec[gi] = data_q[gi+1];
            end
        end
    endgenerate

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (preset_hit) begin
            data_d = PRESET_VAL;
            cnt_d  = '0;
        end else if (en) begin
            case (mode_sel)
                MODE_LOAD: begin
                    data_d = d;
                    cnt_d  = '0;
                end
                MODE_SHL: begin
                    data_d = shl_vec;
                    cnt_d  = cnt_inc;
                end
                MODE_SHR: begin
                    data_d = shr_vec;
                    cnt_d  = cnt_inc;
                end
                default: begin
                    data_d = data_q;
                    cnt_d  = cnt_q;
                end
            endcase
        end
        done_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            data_q <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // sout shows the bit that would leave on a shift in the currently selected direction.
    assign sout = (mode_sel == MODE_SHR) ? data_q[0] : data_q[WIDTH-1];
    assign q    = data_q;
    assign cnt  = cnt_q;
    assign done = done_q;

endmodule
